// File: rtl/l1_cache_wb.sv
// Direct-mapped write-back / write-allocate L1 cache between the mp1 CPU port and line-wide physical memory.
// Optional performance counters (hit/miss/writeback) are built when CACHE_PERF_EN is defined.
module l1_cache_wb #(
    parameter int S_INDEX  = 3,
    parameter int S_OFFSET = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [3:0]   mem_byte_enable,
    input  logic [31:0]  mem_address,
    input  logic [31:0]  mem_wdata,
    output logic [31:0]  mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
`ifdef CACHE_PERF_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count,
    output logic [31:0]  wb_count
`endif
);

    localparam int TAG_W     = 32 - S_OFFSET - S_INDEX;
    localparam int NUM_LINES = 1 << S_INDEX;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_WB    = 2'd2;
    localparam logic [1:0] ST_FILL  = 2'd3;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end
        end
        return res;
    endfunction

    logic [1:0]           state_q, state_d;
    logic                 from_idle_q;
    logic [NUM_LINES-1:0] valid_q, dirty_q;
    logic [255:0]         data_q [NUM_LINES];
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];

    logic [TAG_W-1:0]     req_tag_s;
    logic [S_INDEX-1:0]   req_idx_s;
    logic [2:0]           req_word_s;
    logic [7:0]           word_bit_s;
    logic [255:0]         cur_line_s;
    logic [31:0]          cur_word_s;
    logic                 hit_s;
    logic                 check_s;
    logic                 fill_done_s;
    logic                 wb_done_s;
    logic                 unused_addr_s;

    assign req_tag_s   = mem_address[31 -: TAG_W];
    assign req_idx_s   = mem_address[S_OFFSET +: S_INDEX];
    assign req_word_s  = mem_address[4:2];
    assign word_bit_s  = {req_word_s, 5'b00000};
    assign cur_line_s  = data_q[req_idx_s];
    assign cur_word_s  = cur_line_s[word_bit_s +: 32];
    assign hit_s       = valid_q[req_idx_s] && (tag_q[req_idx_s] == req_tag_s);
    assign check_s     = (state_q == ST_CHECK);
    assign fill_done_s = (state_q == ST_FILL) && pmem_resp;
    assign wb_done_s   = (state_q == ST_WB) && pmem_resp;
    assign unused_addr_s = ^mem_address[1:0];

    // Next-state selection; pmem_resp only matters in the two memory states.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = (mem_read || mem_write) ? ST_CHECK : ST_IDLE;
            ST_CHECK: begin
                if (hit_s) begin
                    state_d = ST_IDLE;
                end else if (dirty_q[req_idx_s]) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_WB:    state_d = pmem_resp ? ST_FILL : ST_WB;
            ST_FILL:  state_d = pmem_resp ? ST_CHECK : ST_FILL;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs decode from the registered state so reset forces them low at once.
    always_comb begin
        mem_resp     = check_s && hit_s;
        mem_rdata    = 32'h0000_0000;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 32'h0000_0000;
        pmem_wdata   = 256'h0;
        if (mem_resp && !mem_write) begin
            mem_rdata = cur_word_s;
        end else begin
            mem_rdata = 32'h0000_0000;
        end
        case (state_q)
            ST_WB: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[req_idx_s], req_idx_s, 5'b00000};
                pmem_wdata   = cur_line_s;
            end
            ST_FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag_s, req_idx_s, 5'b00000};
            end
            default: begin
                pmem_address = 32'h0000_0000;
            end
        endcase
    end

    // Control state: FSM, line valid/dirty flags and the came-from-IDLE marker.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            from_idle_q <= 1'b0;
            valid_q     <= '0;
            dirty_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE) begin
                from_idle_q <= 1'b1;
            end else if (state_q == ST_FILL) begin
                from_idle_q <= 1'b0;
            end
            if (fill_done_s) begin
                valid_q[req_idx_s] <= 1'b1;
                dirty_q[req_idx_s] <= 1'b0;
            end else if (check_s && hit_s && mem_write) begin
                dirty_q[req_idx_s] <= 1'b1;
            end
        end
    end

    // Tag and data arrays keep their contents across reset.
    always_ff @(posedge clk) begin
        if (fill_done_s) begin
            data_q[req_idx_s] <= pmem_rdata;
            tag_q[req_idx_s]  <= req_tag_s;
        end else if (check_s && hit_s && mem_write) begin
            data_q[req_idx_s][word_bit_s +: 32] <= merge_bytes(cur_word_s, mem_wdata, mem_byte_enable);
        end
    end

`ifdef CACHE_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Saturating event counters; refill-driven re-checks are not counted as hits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
            wb_count   <= 32'd0;
        end else begin
            if (check_s && hit_s && from_idle_q) begin
                hit_count <= sat_inc(hit_count);
            end
            if (check_s && !hit_s) begin
                miss_count <= sat_inc(miss_count);
            end
            if (wb_done_s) begin
                wb_count <= sat_inc(wb_count);
            end
        end
    end
`endif

endmodule

// File: tb/tb_l1_cache_wb.sv
// Directed self-checking bench for l1_cache_wb: transaction-level cache model plus 3-cycle line memory.
module tb_l1_cache_wb;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_read, mem_write;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_address, mem_wdata, mem_rdata;
    logic         mem_resp, pmem_read, pmem_write, pmem_resp;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata, pmem_rdata;
`ifdef CACHE_PERF_EN
    logic [31:0]  hit_count, miss_count, wb_count;
`endif

    always #5 clk = ~clk;

    l1_cache_wb #(.S_INDEX(3), .S_OFFSET(5)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
`ifdef CACHE_PERF_EN
        , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] gen_line(input logic [31:0] a);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) begin
            l[w*32 +: 32] = {a[31:5], w[2:0], 2'b00};
        end
        return l;
    endfunction

    // Environment memory (written by the DUT) and the model's own view of memory.
    logic [255:0] env_mem [logic [31:0]];
    logic [255:0] m_mem   [logic [31:0]];
    logic [255:0] m_line  [8];
    logic [23:0]  m_tag   [8];
    bit           m_valid [8];
    bit           m_dirty [8];

    function automatic logic [255:0] env_get(input logic [31:0] a);
        return env_mem.exists(a) ? env_mem[a] : gen_line(a);
    endfunction

    function automatic logic [255:0] model_get(input logic [31:0] a);
        return m_mem.exists(a) ? m_mem[a] : gen_line(a);
    endfunction

    function automatic logic [31:0] apply_be(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        return {be[3] ? n[31:24] : o[31:24], be[2] ? n[23:16] : o[23:16],
                be[1] ? n[15:8]  : o[15:8],  be[0] ? n[7:0]   : o[7:0]};
    endfunction

    // Memory responder: pmem_resp rises in the 3rd cycle a request is held.
    int rcnt = 0;
    int stray_req = 0;
    int stray_ack = 0;
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (pmem_resp) begin
                pmem_resp = 1'b0;
                rcnt = 0;
            end
            if (pmem_read || pmem_write) begin
                rcnt++;
                if (rcnt == 3) begin
                    pmem_resp = 1'b1;
                    if (pmem_write) env_mem[pmem_address] = pmem_wdata;
                    else pmem_rdata = env_get(pmem_address);
                end
            end else begin
                rcnt = 0;
                if (stray_req != stray_ack) begin
                    stray_ack = stray_req;
                    pmem_resp = 1'b1;
                end
            end
        end
    end

    logic [31:0] last_rdata, last_fill_addr, last_wb_addr, last_wb_w1;

    // One CPU transaction: predict from the model, drive, then check every cycle until mem_resp.
    task automatic do_req(input string tn, input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] be);
        int idx, wrd, exp_lat, seen_wb, seen_fill;
        bit hit, exp_wb, done;
        logic [23:0] tg;
        logic [31:0] wb_addr, fill_addr, exp_rd;
        logic [255:0] wb_data;
        idx = int'(addr[7:5]);
        wrd = int'(addr[4:2]);
        tg  = addr[31:8];
        hit = m_valid[idx] && (m_tag[idx] == tg);
        exp_wb    = !hit && m_dirty[idx];
        wb_addr   = {m_tag[idx], addr[7:5], 5'b00000};
        wb_data   = m_line[idx];
        fill_addr = {addr[31:5], 5'b00000};
        exp_lat   = 2 + (hit ? 0 : 4) + (exp_wb ? 3 : 0);
        if (!hit) begin
            if (exp_wb) m_mem[wb_addr] = wb_data;
            m_line[idx]  = model_get(fill_addr);
            m_tag[idx]   = tg;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
        end
        exp_rd = m_line[idx][wrd*32 +: 32];
        if (wr) begin
            m_line[idx][wrd*32 +: 32] = apply_be(exp_rd, wd, be);
            m_dirty[idx] = 1'b1;
        end

        @(posedge clk);
        #1;
        mem_read = rd; mem_write = wr; mem_address = addr; mem_wdata = wd; mem_byte_enable = be;
        seen_wb = 0; seen_fill = 0; done = 1'b0;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clk);
            chk({tn, "_pmem_excl"}, pmem_read && pmem_write, 1'b0);
            chk({tn, "_resp_vs_pmem"}, mem_resp && (pmem_read || pmem_write), 1'b0);
            if (pmem_write) begin
                seen_wb++;
                chk({tn, "_wb_addr"}, pmem_address, wb_addr);
                chk({tn, "_wb_data"}, pmem_wdata, wb_data);
                last_wb_addr = pmem_address;
                last_wb_w1   = pmem_wdata[63:32];
            end
            if (pmem_read) begin
                seen_fill++;
                chk({tn, "_fill_addr"}, pmem_address, fill_addr);
                chk({tn, "_fill_after_wb"}, seen_wb != 0, exp_wb);
                last_fill_addr = pmem_address;
            end
            if (mem_resp) begin
                done = 1'b1;
                chk({tn, "_latency"}, c, exp_lat);
                if (!wr) begin
                    chk({tn, "_rdata"}, mem_rdata, exp_rd);
                    last_rdata = mem_rdata;
                end
            end
        end
        chk({tn, "_resp_seen"}, done, 1'b1);
        chk({tn, "_wb_seen"}, seen_wb != 0, exp_wb);
        chk({tn, "_fill_seen"}, seen_fill != 0, !hit);
    endtask

    task automatic go_idle();
        @(posedge clk);
        #1;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    initial begin
        bit fill_started;
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0; m_line[i] = '0;
        end
        rst = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = 4'b0000;
        mem_address = 32'h0; mem_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_resp", mem_resp, 1'b0);
        chk("rst_pmem_read", pmem_read, 1'b0);
        chk("rst_pmem_write", pmem_write, 1'b0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        chk("rst_pmem_addr", pmem_address, 32'h0);
        chk("rst_pmem_wdata", pmem_wdata, 256'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        do_req("t1", 1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'b0000);
        chk("t1_lit_fill", last_fill_addr, 32'h0000_0040);
        chk("t1_lit_rdata", last_rdata, 32'h0000_0040);
        do_req("t2", 1'b1, 1'b0, 32'h0000_004C, 32'h0, 4'b0000);
        chk("t2_lit_rdata", last_rdata, 32'h0000_004C);
        do_req("t3w", 1'b0, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 4'b0011);
        do_req("t3r", 1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'b0000);
        chk("t3_lit_rdata", last_rdata, 32'h0000_BEEF);
        do_req("t4", 1'b1, 1'b0, 32'h0000_0140, 32'h0, 4'b0000);
        chk("t4_lit_wb_addr", last_wb_addr, 32'h0000_0040);
        chk("t4_lit_wb_w1", last_wb_w1, 32'h0000_BEEF);
        chk("t4_lit_fill", last_fill_addr, 32'h0000_0140);
        chk("t4_lit_rdata", last_rdata, 32'h0000_0140);
`ifdef CACHE_PERF_EN
        go_idle();
        chk("perf_hit", hit_count, 32'd3);
        chk("perf_miss", miss_count, 32'd2);
        chk("perf_wb", wb_count, 32'd1);
`endif
        // Zero byte enables still dirty the line; the writeback later carries it unchanged.
        do_req("be0w", 1'b0, 1'b1, 32'h0000_0148, 32'hFFFF_FFFF, 4'b0000);
        do_req("be0r", 1'b1, 1'b0, 32'h0000_0148, 32'h0, 4'b0000);
        chk("be0_lit_rdata", last_rdata, 32'h0000_0148);
        do_req("refetch", 1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'b0000);
        chk("refetch_lit_wb_addr", last_wb_addr, 32'h0000_0140);
        chk("refetch_lit_rdata", last_rdata, 32'h0000_BEEF);
        do_req("prio_w", 1'b1, 1'b1, 32'h0000_0060, 32'h1234_5678, 4'b1111);
        do_req("prio_r", 1'b1, 1'b0, 32'h0000_0060, 32'h0, 4'b0000);
        chk("prio_lit_rdata", last_rdata, 32'h1234_5678);
        do_req("hi_w", 1'b0, 1'b1, 32'hFFFF_FFE0, 32'hAB00_0000, 4'b1000);
        do_req("hi_r", 1'b1, 1'b0, 32'hFFFF_FFE0, 32'h0, 4'b0000);
        chk("hi_lit_rdata", last_rdata, 32'hABFF_FFE0);

        go_idle();
        stray_req++;
        repeat (3) @(posedge clk);
        do_req("stray", 1'b1, 1'b0, 32'h0000_0064, 32'h0, 4'b0000);

        // Reset in the middle of a fill, then the line must miss again.
        @(posedge clk);
        #1;
        mem_read = 1'b1; mem_write = 1'b0; mem_address = 32'h0000_0240;
        fill_started = 1'b0;
        for (int c = 0; c < 20 && !fill_started; c++) begin
            @(negedge clk);
            fill_started = pmem_read;
        end
        chk("t5_fill_started", fill_started, 1'b1);
        rst = 1'b0;
        #1;
        chk("t5_pmem_read_drop", pmem_read, 1'b0);
        chk("t5_pmem_write_low", pmem_write, 1'b0);
        chk("t5_mem_resp_low", mem_resp, 1'b0);
        chk("t5_pmem_addr_zero", pmem_address, 32'h0);
        mem_read = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0; m_dirty[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        do_req("t5", 1'b1, 1'b0, 32'h0000_0140, 32'h0, 4'b0000);
        chk("t5_lit_fill", last_fill_addr, 32'h0000_0140);
        chk("t5_lit_rdata", last_rdata, 32'h0000_0140);
        go_idle();
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
